wishbone_xfer_engine: RTL and testbench
=======================================

Name: wishbone_xfer_engine

Overview:
- Parametrised successor to the UART gateway's Wishbone transfer FSM.
- Adds:
  - configurable data and address widths
  - a buffered write queue in place of the fixed back-pressure timer
  - per-transfer addressing
  - round-robin read/write arbitration
  - explicit timeout and drop reporting
- Sits between the UART transfer handler and the Wishbone peripheral bus as the single Wishbone master.

Parameters:
- DATA_W, 8, Wishbone data width in bits.
- ADDR_W, 3, Wishbone address width in bits.
- WR_FIFO_DEPTH, 4, write-queue entries; power of two, ≥2.
- ACK_TIMEOUT_CYCLES, 5, maximum cycles cyc/stb are held awaiting ack; ≥2.
- FLIP_BIT_ORDER, 0, when 1, the bit order of wb_dat_o and wb_dat_i is reversed at the bus boundary.
- MAX_RETRIES, 2, write reissues after timeout; used only with the optional feature.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- wr_en  in  1  pulse: push {wr_addr, wr_data} into the write queue
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_busy  out  1  write queue full
- wr_drop  out  1  pulse: wr_en arrived while full; request discarded
- wr_ack  out  1  pulse: write acknowledged by slave
- wr_timeout  out  1  pulse: write abandoned
- rd_req  in  1  level: read wanted (interrupt)
- rd_addr  in  ADDR_W  read address, sampled at grant
- rd_data  out  DATA_W  captured read data
- rd_valid  out  1  level: rd_data valid
- rd_ack  in  1  pulse: consumer took rd_data
- rd_timeout  out  1  pulse: read abandoned
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone controls
- wb_sel_o  out  DATA_W/8 (min 1)  byte selects, all ones
- wb_adr_o  out  ADDR_W  address
- wb_dat_o  out  DATA_W  write data
- wb_dat_i  in  DATA_W  read data
- wb_ack_i  in  1  slave ack

Behaviour:
- Reset values:
  - all outputs 0
  - queue empty
  - state IDLE
  - last_grant = READ, so the first contended grant goes to write
  - reset mid-transfer drops cyc/stb immediately and discards queue contents
- Write queue:
  - synchronous FIFO; push on wr_en when not full
  - wr_en when full: wr_drop pulses in the same cycle; queue unchanged
  - simultaneous push and pop allowed when full
  - wr_busy = full, combinational from the count
- States: IDLE, WR_ACTIVE, RD_ACTIVE.
- IDLE:
  - write pending = queue not empty
  - read pending = rd_req & ~rd_valid; reads are blocked while rd_valid=1, so there is no overrun
  - both pending: grant the type opposite to last_grant; otherwise grant whichever is pending
  - grant registers the address (queue head or rd_addr), data and we, updates last_grant, clears the timer, and moves to *_ACTIVE the next cycle
- *_ACTIVE:
  - wb_cyc_o = wb_stb_o = 1; wb_we_o = 1 only in WR_ACTIVE
  - adr and dat are stable for the whole phase
  - timer increments each cycle
- Ack in WR_ACTIVE: pop the queue, wr_ack pulses the next cycle, go to IDLE.
- Ack in RD_ACTIVE: capture wb_dat_i into rd_data, set rd_valid next cycle, go to IDLE.
- Timeout:
  - ack absent when timer == ACK_TIMEOUT_CYCLES-1: drop cyc/stb, go to IDLE, pulse wr_timeout or rd_timeout next cycle
  - a write timeout pops (discards) the entry
  - ack on the final timer cycle wins over timeout
- IDLE always lasts ≥1 cycle between transfers: cyc deasserts for at least one cycle.
- wb_ack_i outside *_ACTIVE is ignored.
- rd_valid:
  - set by read completion, cleared by rd_ack
  - if set and clear coincide, set wins; cannot occur because of read gating
- Latency:
  - wr_en to wb_cyc_o is 2 cycles with the bus idle
  - ack to wr_ack or rd_valid is 1 cycle

Optional Feature:
- Macro: WB_XFER_RETRY_EN.
- Defined:
  - a write timeout does not pop the entry
  - a per-entry retry counter increments and the write is re-arbitrated as pending
  - after MAX_RETRIES reissues the next timeout pops the entry and pulses wr_timeout
  - wr_ack or pop clears the counter
  - reads never retry
- Undefined: no retry counter; every timeout is final as described above.

Decomposition:
- Package wb_xfer_pkg holds:
  - the state enum typedef
  - the grant enum typedef (READ/WRITE)
  - the write entry struct {addr, data}
  - the default timeout constant
- Sub-module wb_xfer_fifo: parametrised synchronous FIFO, depth WR_FIFO_DEPTH, full/empty flags, same clk/rstn.

Test Plan:
- Single write: wr_en with addr 3, data 0xA5; slave acks on the 2nd active cycle → cyc high 2 cycles, we=1, adr=3, dat=0xA5; wr_ack pulses once; queue empty.
- Queue fill: 5 back-to-back wr_en, depth 4, slave stalled → wr_busy after the 4th; wr_drop pulses on the 5th; the 4 writes are issued in order once acks resume.
- Arbitration: rd_req held, 3 writes queued → bus order W, R, W, W (read then blocked on rd_valid); rd_data equals wb_dat_i on the ack cycle.
- Timeout: no ack, ACK_TIMEOUT_CYCLES=5 → cyc exactly 5 cycles, wr_timeout pulses, entry discarded; ack on the 5th cycle → wr_ack, no timeout.
- Retry (WB_XFER_RETRY_EN, MAX_RETRIES=2): slave never acks → 3 transfers of 5 cycles each, then a single wr_timeout.
- Reset mid WR_ACTIVE: rstn low → cyc/stb 0 immediately; after release queue empty, rd_valid 0.

Source files
------------

// File: rtl/wb_xfer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_xfer_pkg
// Description : Shared types and constants for the Wishbone transfer engine.
//               - xfer_state_t : engine FSM states
//               - grant_t      : last granted transfer type (read/write)
//               - wr_entry_t   : write-queue entry layout at the default widths
//               - WB_XFER_DEF_TIMEOUT : default ack timeout in cycles
// Revision    : 1.0 - initial release
// ============================================================================
package wb_xfer_pkg;

  localparam int unsigned WB_XFER_DEF_TIMEOUT = 5;

  // Widths of the default configuration; the engine builds its own
  // entry type from its parameters when they differ.
  localparam int unsigned WB_XFER_DEF_ADDR_W = 3;
  localparam int unsigned WB_XFER_DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WR_ACTIVE = 2'd1,
    ST_RD_ACTIVE = 2'd2
  } xfer_state_t;

  typedef enum logic {
    GNT_READ  = 1'b0,
    GNT_WRITE = 1'b1
  } grant_t;

  typedef struct packed {
    logic [WB_XFER_DEF_ADDR_W-1:0] addr;
    logic [WB_XFER_DEF_DATA_W-1:0] data;
  } wr_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_xfer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_xfer_fifo
// Description : Synchronous FIFO holding pending write requests. Head entry
//               is presented combinationally. A push while full is accepted
//               only when a pop happens in the same cycle.
// Ports       : clk, rstn      clock / asynchronous active-low reset
//               push_i, wdata_i push request and its payload
//               pop_i           remove head entry (ignored when empty)
//               rdata_o         head entry
//               full_o, empty_o occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module wb_xfer_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/wishbone_xfer_engine.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_xfer_engine
// Description : Single Wishbone master between the UART transfer handler and
//               the peripheral bus. Queues writes, serves level-requested
//               reads, arbitrates round-robin, and reports ack timeouts and
//               dropped writes.
// Ports       : clk, rstn                      clock / async active-low reset
//               wr_en, wr_addr, wr_data        write request into the queue
//               wr_busy, wr_drop               queue full / request discarded
//               wr_ack, wr_timeout             write completed / abandoned
//               rd_req, rd_addr                read request (level) + address
//               rd_data, rd_valid, rd_ack      read result handshake
//               rd_timeout                     read abandoned
//               wb_*                           Wishbone master interface
// Options     : WB_XFER_RETRY_EN - a timed-out write is reissued up to
//               MAX_RETRIES times before being discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module wishbone_xfer_engine
  import wb_xfer_pkg::*;
#(
  parameter int unsigned DATA_W             = 8,
  parameter int unsigned ADDR_W             = 3,
  parameter int unsigned WR_FIFO_DEPTH      = 4,
  parameter int unsigned ACK_TIMEOUT_CYCLES = WB_XFER_DEF_TIMEOUT,
  parameter int unsigned FLIP_BIT_ORDER     = 0,
  parameter int unsigned MAX_RETRIES        = 2
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic                                     wr_en,
  input  logic [ADDR_W-1:0]                        wr_addr,
  input  logic [DATA_W-1:0]                        wr_data,
  output logic                                     wr_busy,
  output logic                                     wr_drop,
  output logic                                     wr_ack,
  output logic                                     wr_timeout,
  input  logic                                     rd_req,
  input  logic [ADDR_W-1:0]                        rd_addr,
  output logic [DATA_W-1:0]                        rd_data,
  output logic                                     rd_valid,
  input  logic                                     rd_ack,
  output logic                                     rd_timeout,
  output logic                                     wb_cyc_o,
  output logic                                     wb_stb_o,
  output logic                                     wb_we_o,
  output logic [((DATA_W/8 < 1) ? 1 : DATA_W/8)-1:0] wb_sel_o,
  output logic [ADDR_W-1:0]                        wb_adr_o,
  output logic [DATA_W-1:0]                        wb_dat_o,
  input  logic [DATA_W-1:0]                        wb_dat_i,
  input  logic                                     wb_ack_i
);

  localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT_CYCLES - 1);

  if ((WR_FIFO_DEPTH < 2) || ((WR_FIFO_DEPTH & (WR_FIFO_DEPTH - 1)) != 0) ||
      (ACK_TIMEOUT_CYCLES < 2) || (MAX_RETRIES > 255)) begin : g_param_check
    $error("wishbone_xfer_engine: illegal parameter combination");
  end

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            push_ent;
  entry_t            head_ent;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;

  xfer_state_t       state_q;
  grant_t            last_grant_q;
  logic              cyc_q;
  logic              we_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] dat_q;
  logic [TMR_W-1:0]  timer_q;
  logic              wr_ack_q;
  logic              wr_timeout_q;
  logic              rd_timeout_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  logic              wr_pend;
  logic              rd_pend;
  logic              grant_wr;
  logic              grant_rd;
  logic              timer_last;
  logic              wr_final;
  logic [DATA_W-1:0] bus_dat_in;

  assign push_ent = '{addr: wr_addr, data: wr_data};

  wb_xfer_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (WR_FIFO_DEPTH)
  ) u_wr_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (wr_en),
    .wdata_i (push_ent),
    .pop_i   (fifo_pop),
    .rdata_o (head_ent),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Reads are held off while an unconsumed result is pending.
  assign wr_pend  = ~fifo_empty;
  assign rd_pend  = rd_req & ~rd_valid_q;
  assign grant_wr = wr_pend & (~rd_pend | (last_grant_q == GNT_READ));
  assign grant_rd = rd_pend & ~grant_wr;

  assign timer_last = (timer_q == TMR_LAST);

  // The head leaves the queue on ack, or on a timeout that is final.
  assign fifo_pop = (state_q == ST_WR_ACTIVE) & (wb_ack_i | (timer_last & wr_final));

  // A full-queue push survives only if the head leaves in the same cycle.
  assign wr_drop = wr_en & fifo_full & ~fifo_pop;
  assign wr_busy = fifo_full;

`ifdef WB_XFER_RETRY_EN
  localparam int unsigned RTY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  logic [RTY_W-1:0] retry_q;

  assign wr_final = (retry_q == RTY_W'(MAX_RETRIES));

  // Counts reissues of the current head entry only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retry_q <= '0;
    end else if (fifo_pop) begin
      retry_q <= '0;
    end else if ((state_q == ST_WR_ACTIVE) && timer_last && !wb_ack_i) begin
      retry_q <= retry_q + RTY_W'(1);
    end
  end
`else
  assign wr_final = 1'b1;
`endif

  if (FLIP_BIT_ORDER != 0) begin : g_flip
    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
      assign wb_dat_o[b]   = dat_q[DATA_W-1-b];
      assign bus_dat_in[b] = wb_dat_i[DATA_W-1-b];
    end
  end else begin : g_straight
    assign wb_dat_o   = dat_q;
    assign bus_dat_in = wb_dat_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_READ;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      timer_q      <= '0;
      wr_ack_q     <= 1'b0;
      wr_timeout_q <= 1'b0;
      rd_timeout_q <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      wr_ack_q     <= 1'b0;
      wr_timeout_q <= 1'b0;
      rd_timeout_q <= 1'b0;
      // Clear first so a same-cycle read completion below takes priority.
      if (rd_ack) rd_valid_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (grant_wr) begin
            state_q      <= ST_WR_ACTIVE;
            cyc_q        <= 1'b1;
            we_q         <= 1'b1;
            adr_q        <= head_ent.addr;
            dat_q        <= head_ent.data;
            last_grant_q <= GNT_WRITE;
            timer_q      <= '0;
          end else if (grant_rd) begin
            state_q      <= ST_RD_ACTIVE;
            cyc_q        <= 1'b1;
            we_q         <= 1'b0;
            adr_q        <= rd_addr;
            last_grant_q <= GNT_READ;
            timer_q      <= '0;
          end
        end

        ST_WR_ACTIVE: begin
          if (wb_ack_i) begin
            state_q  <= ST_IDLE;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            wr_ack_q <= 1'b1;
          end else if (timer_last) begin
            state_q      <= ST_IDLE;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            wr_timeout_q <= wr_final;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end

        ST_RD_ACTIVE: begin
          if (wb_ack_i) begin
            state_q    <= ST_IDLE;
            cyc_q      <= 1'b0;
            rd_data_q  <= bus_dat_in;
            rd_valid_q <= 1'b1;
          end else if (timer_last) begin
            state_q      <= ST_IDLE;
            cyc_q        <= 1'b0;
            rd_timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cyc_q   <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_we_o    = we_q;
  assign wb_sel_o   = '1;
  assign wb_adr_o   = adr_q;
  assign wr_ack     = wr_ack_q;
  assign wr_timeout = wr_timeout_q;
  assign rd_timeout = rd_timeout_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_xfer_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_wishbone_xfer_engine
// Description : Directed self-checking bench for wishbone_xfer_engine at its
//               default parameters. A Wishbone slave model acks after a
//               programmable number of active cycles (0 = never); read data
//               is 0x90 XOR address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wishbone_xfer_engine;

`ifdef WB_XFER_RETRY_EN
  localparam int EXP_XFERS = 3;
`else
  localparam int EXP_XFERS = 1;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       rd_req = 1'b0;
  logic [2:0] rd_addr = '0;
  logic       rd_ack = 1'b0;
  wire        wr_busy, wr_drop, wr_ack, wr_timeout;
  wire  [7:0] rd_data;
  wire        rd_valid, rd_timeout;
  wire        wb_cyc_o, wb_stb_o, wb_we_o;
  wire  [0:0] wb_sel_o;
  wire  [2:0] wb_adr_o;
  wire  [7:0] wb_dat_o;
  wire  [7:0] wb_dat_i;
  wire        wb_ack_i;

  int n_checks = 0;
  int n_fail   = 0;

  int ack_delay = 0;
  int act_cnt   = 0;

  int   cyc_cycles = 0, xfer_starts = 0, n_wr_ack = 0, n_wr_to = 0, n_rd_to = 0;
  int   log_n = 0;
  bit   cyc_prev = 1'b0;
  logic       log_we  [0:255];
  logic [2:0] log_adr [0:255];
  logic [7:0] log_dat [0:255];

  wishbone_xfer_engine dut (
    .clk        (clk),
    .rstn       (rstn),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_busy    (wr_busy),
    .wr_drop    (wr_drop),
    .wr_ack     (wr_ack),
    .wr_timeout (wr_timeout),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ack     (rd_ack),
    .rd_timeout (rd_timeout),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_sel_o   (wb_sel_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i)
  );

  always #5 clk = ~clk;

  // Slave model
  always @(posedge clk) begin
    if (wb_cyc_o) act_cnt <= act_cnt + 1;
    else          act_cnt <= 0;
  end
  assign wb_ack_i = (ack_delay != 0) && wb_cyc_o && (act_cnt == ack_delay - 1);
  assign wb_dat_i = 8'h90 ^ {5'b0, wb_adr_o};

  // Bus / status monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (wb_cyc_o) cyc_cycles = cyc_cycles + 1;
    if (wb_cyc_o && !cyc_prev) xfer_starts = xfer_starts + 1;
    cyc_prev = wb_cyc_o;
    if (wr_ack)     n_wr_ack = n_wr_ack + 1;
    if (wr_timeout) n_wr_to  = n_wr_to + 1;
    if (rd_timeout) n_rd_to  = n_rd_to + 1;
    if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
      log_we[log_n[7:0]]  = wb_we_o;
      log_adr[log_n[7:0]] = wb_adr_o;
      log_dat[log_n[7:0]] = wb_we_o ? wb_dat_o : wb_dat_i;
      log_n = log_n + 1;
    end
  end

  task automatic cyc1();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    cyc1();
    cyc1();
    n_checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got %h expected 0", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o});
    end
    n_checks++;
    if ({wr_busy, wr_drop, wr_ack, wr_timeout, rd_valid, rd_timeout} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_status: got %b expected 000000",
               {wr_busy, wr_drop, wr_ack, wr_timeout, rd_valid, rd_timeout});
    end
    n_checks++;
    if (rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rd_data: got %h expected 00", rd_data);
    end
    n_checks++;
    if (wb_sel_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_sel: got %b expected 1", wb_sel_o);
    end
    rstn = 1'b1;
    cyc1();
    cyc1();
    n_checks++;
    if (wb_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_cyc: got %b expected 0", wb_cyc_o);
    end
  endtask

  // First contended grant after reset goes to the write.
  task automatic test_arbitration();
    int l0 = log_n;
    int a0 = n_wr_ack;
    logic       e_we  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0] e_adr [4] = '{3'd1, 3'd5, 3'd2, 3'd4};
    logic [7:0] e_dat [4] = '{8'h11, 8'h95, 8'h22, 8'h44};
    ack_delay = 1;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h11;
    cyc1();
    wr_addr = 3'd2; wr_data = 8'h22; rd_req = 1'b1; rd_addr = 3'd5;
    cyc1();
    wr_addr = 3'd4; wr_data = 8'h44;
    cyc1();
    wr_en = 1'b0;
    for (int i = 0; i < 60 && (log_n - l0) < 4; i++) cyc1();
    repeat (3) cyc1();
    n_checks++;
    if (log_n - l0 !== 4) begin
      n_fail++;
      $display("FAIL arb_count: got %0d transfers expected 4", log_n - l0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if ({log_we[l0+k], log_adr[l0+k], log_dat[l0+k]} !== {e_we[k], e_adr[k], e_dat[k]}) begin
          n_fail++;
          $display("FAIL arb_order[%0d]: got we=%b adr=%0d dat=%h expected we=%b adr=%0d dat=%h", k,
                   log_we[l0+k], log_adr[l0+k], log_dat[l0+k], e_we[k], e_adr[k], e_dat[k]);
        end
      end
    end
    n_checks++;
    if ({rd_valid, rd_data} !== {1'b1, 8'h95}) begin
      n_fail++;
      $display("FAIL arb_rd_data: got valid=%b data=%h expected valid=1 data=95", rd_valid, rd_data);
    end
    n_checks++;
    if (n_wr_ack - a0 !== 3) begin
      n_fail++;
      $display("FAIL arb_wr_ack: got %0d expected 3", n_wr_ack - a0);
    end
    rd_ack = 1'b1; rd_req = 1'b0;
    cyc1();
    rd_ack = 1'b0;
    n_checks++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arb_rd_clear: got %b expected 0", rd_valid);
    end
  endtask

  task automatic test_single_write();
    int c0 = cyc_cycles;
    int a0 = n_wr_ack;
    int l0 = log_n;
    int s0 = xfer_starts;
    ack_delay = 2;
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
    cyc1();
    wr_en = 1'b0;
    n_checks++;
    if (wb_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_latency1: cyc got %b expected 0", wb_cyc_o);
    end
    cyc1();
    n_checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o} !== {3'b111, 3'd3, 8'hA5}) begin
      n_fail++;
      $display("FAIL sw_bus: got cyc=%b stb=%b we=%b adr=%0d dat=%h expected 1 1 1 3 a5",
               wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o);
    end
    cyc1();
    cyc1();
    n_checks++;
    if ({wb_cyc_o, wr_ack} !== 2'b01) begin
      n_fail++;
      $display("FAIL sw_ack: got cyc=%b wr_ack=%b expected cyc=0 wr_ack=1", wb_cyc_o, wr_ack);
    end
    cyc1();
    n_checks++;
    if (wr_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_ack_pulse: got %b expected 0", wr_ack);
    end
    repeat (6) cyc1();
    n_checks++;
    if (cyc_cycles - c0 !== 2) begin
      n_fail++;
      $display("FAIL sw_cyc_len: got %0d expected 2", cyc_cycles - c0);
    end
    n_checks++;
    if ({n_wr_ack - a0, log_n - l0, xfer_starts - s0} !== {32'd1, 32'd1, 32'd1}) begin
      n_fail++;
      $display("FAIL sw_counts: got acks=%0d logged=%0d starts=%0d expected 1 1 1",
               n_wr_ack - a0, log_n - l0, xfer_starts - s0);
    end
    n_checks++;
    if (wr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_busy: got %b expected 0", wr_busy);
    end
  endtask

  task automatic test_queue_fill();
    int l0 = log_n;
    int a0 = n_wr_ack;
    int t0 = n_wr_to;
    ack_delay = 5;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'hB0 + 8'(i);
      #1;
      if (i == 3) begin
        n_checks++;
        if ({wr_busy, wr_drop} !== 2'b00) begin
          n_fail++;
          $display("FAIL qf_4th: got busy=%b drop=%b expected 0 0", wr_busy, wr_drop);
        end
      end
      if (i == 4) begin
        n_checks++;
        if ({wr_busy, wr_drop} !== 2'b11) begin
          n_fail++;
          $display("FAIL qf_5th: got busy=%b drop=%b expected 1 1", wr_busy, wr_drop);
        end
      end
      cyc1();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 100 && (log_n - l0) < 4; i++) cyc1();
    repeat (12) cyc1();
    n_checks++;
    if (log_n - l0 !== 4) begin
      n_fail++;
      $display("FAIL qf_count: got %0d transfers expected 4", log_n - l0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if ({log_we[l0+k], log_adr[l0+k], log_dat[l0+k]} !== {1'b1, 3'(k), 8'hB0 + 8'(k)}) begin
          n_fail++;
          $display("FAIL qf_order[%0d]: got we=%b adr=%0d dat=%h expected we=1 adr=%0d dat=%h", k,
                   log_we[l0+k], log_adr[l0+k], log_dat[l0+k], k, 8'hB0 + 8'(k));
        end
      end
    end
    n_checks++;
    if ({n_wr_ack - a0, n_wr_to - t0} !== {32'd4, 32'd0}) begin
      n_fail++;
      $display("FAIL qf_acks: got acks=%0d timeouts=%0d expected 4 0", n_wr_ack - a0, n_wr_to - t0);
    end
  endtask

  task automatic test_timeout();
    int c0 = cyc_cycles;
    int s0 = xfer_starts;
    int t0 = n_wr_to;
    int a0 = n_wr_ack;
    int l0 = log_n;
    ack_delay = 0;
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'h5A;
    cyc1();
    wr_en = 1'b0;
    for (int i = 0; i < 80 && n_wr_to == t0; i++) cyc1();
    repeat (10) cyc1();
    n_checks++;
    if (n_wr_to - t0 !== 1) begin
      n_fail++;
      $display("FAIL to_pulses: got %0d expected 1", n_wr_to - t0);
    end
    n_checks++;
    if (cyc_cycles - c0 !== 5 * EXP_XFERS) begin
      n_fail++;
      $display("FAIL to_cyc_len: got %0d expected %0d", cyc_cycles - c0, 5 * EXP_XFERS);
    end
    n_checks++;
    if (xfer_starts - s0 !== EXP_XFERS) begin
      n_fail++;
      $display("FAIL to_starts: got %0d expected %0d", xfer_starts - s0, EXP_XFERS);
    end
    n_checks++;
    if ({n_wr_ack - a0, log_n - l0} !== {32'd0, 32'd0} || wr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL to_discard: got acks=%0d logged=%0d busy=%b expected 0 0 0",
               n_wr_ack - a0, log_n - l0, wr_busy);
    end
    // Ack on the final timer cycle wins
    c0 = cyc_cycles; t0 = n_wr_to; a0 = n_wr_ack; l0 = log_n;
    ack_delay = 5;
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'hC3;
    cyc1();
    wr_en = 1'b0;
    for (int i = 0; i < 30 && n_wr_ack == a0; i++) cyc1();
    repeat (3) cyc1();
    n_checks++;
    if ({n_wr_ack - a0, n_wr_to - t0, cyc_cycles - c0} !== {32'd1, 32'd0, 32'd5}) begin
      n_fail++;
      $display("FAIL to_last_ack: got acks=%0d timeouts=%0d cyc=%0d expected 1 0 5",
               n_wr_ack - a0, n_wr_to - t0, cyc_cycles - c0);
    end
    n_checks++;
    if (log_n - l0 !== 1 || {log_adr[l0], log_dat[l0]} !== {3'd7, 8'hC3}) begin
      n_fail++;
      $display("FAIL to_last_data: got logged=%0d adr=%0d dat=%h expected 1 7 c3",
               log_n - l0, log_adr[l0], log_dat[l0]);
    end
  endtask

  task automatic test_read_timeout();
    int c0 = cyc_cycles;
    int s0 = xfer_starts;
    int r0 = n_rd_to;
    bit seen = 1'b0;
    ack_delay = 0;
    rd_addr = 3'd2; rd_req = 1'b1;
    for (int i = 0; i < 30 && !seen; i++) begin
      cyc1();
      if (rd_timeout) seen = 1'b1;
    end
    rd_req = 1'b0;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rto_seen: got no rd_timeout expected a pulse");
    end
    repeat (4) cyc1();
    n_checks++;
    if ({cyc_cycles - c0, xfer_starts - s0, n_rd_to - r0} !== {32'd5, 32'd1, 32'd1}) begin
      n_fail++;
      $display("FAIL rto_counts: got cyc=%0d starts=%0d pulses=%0d expected 5 1 1",
               cyc_cycles - c0, xfer_starts - s0, n_rd_to - r0);
    end
    n_checks++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rto_valid: got %b expected 0", rd_valid);
    end
  endtask

  task automatic test_reset_mid_write();
    int s0;
    ack_delay = 1;
    rd_addr = 3'd7; rd_req = 1'b1;
    for (int i = 0; i < 20 && !rd_valid; i++) cyc1();
    rd_req = 1'b0;
    n_checks++;
    if ({rd_valid, rd_data} !== {1'b1, 8'h97}) begin
      n_fail++;
      $display("FAIL rst_pre_read: got valid=%b data=%h expected 1 97", rd_valid, rd_data);
    end
    ack_delay = 0;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h01;
    cyc1();
    wr_addr = 3'd2; wr_data = 8'h02;
    cyc1();
    wr_en = 1'b0;
    for (int i = 0; i < 20 && !wb_cyc_o; i++) cyc1();
    n_checks++;
    if (wb_cyc_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_active: got cyc=%b expected 1", wb_cyc_o);
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({wb_cyc_o, wb_stb_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_drop_cyc: got %b expected 00", {wb_cyc_o, wb_stb_o});
    end
    cyc1();
    rstn = 1'b1;
    cyc1();
    n_checks++;
    if ({rd_valid, wr_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_after: got valid=%b busy=%b expected 0 0", rd_valid, wr_busy);
    end
    s0 = xfer_starts;
    repeat (10) cyc1();
    n_checks++;
    if (xfer_starts - s0 !== 0) begin
      n_fail++;
      $display("FAIL rst_queue_empty: got %0d transfers expected 0", xfer_starts - s0);
    end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_single_write();
    test_queue_fill();
    test_timeout();
    test_read_timeout();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
